segre_mem_arbiter: RTL and testbench
====================================

// Module: segre_mem_arbiter
// PURPOSE
// - Shares the single external memory port between three requesters: D-cache line fill, I-cache line fill, store-buffer drain.
// - Sits between the cache/store-buffer miss logic and main memory. Sequences one transaction at a time and returns fill data/acks.
// - Enforces store-before-load ordering on a shared line, plus a watchdog on memory latency.
// PARAMETERS
// - ADDR_SIZE   32   address width
// - WORD_SIZE   32   store data width
// - LANE_SIZE   128  cache line width (DCACHE_LANE_SIZE == ICACHE_LANE_SIZE)
// - BYTE_SIZE   4    line offset bits
// - TIMEOUT     255  max cycles waiting on mem_ready_i before the error flag is raised
// PORTS
// - clk_i            in   1          clock
// - rst_i            in   1          synchronous reset, active-high
// - dc_req_i         in   1          D-cache miss fill request (level, held until dc_rdy_o)
// - dc_addr_i        in   ADDR_SIZE  D-cache miss address
// - dc_rdy_o         out  1          1-cycle pulse: dc_data_o valid
// - dc_data_o        out  LANE_SIZE  D-cache fill line
// - ic_req_i         in   1          I-cache miss fill request (level, held until ic_rdy_o)
// - ic_addr_i        in   ADDR_SIZE  I-cache miss address
// - ic_rdy_o         out  1          1-cycle pulse: ic_data_o valid
// - ic_data_o        out  LANE_SIZE  I-cache fill line
// - sb_req_i         in   1          store buffer has an entry to drain (level)
// - sb_addr_i        in   ADDR_SIZE  store address
// - sb_data_i        in   WORD_SIZE  store data
// - sb_type_i        in   2          memop_data_type_e (BYTE/HALF/WORD)
// - sb_ack_o         out  1          1-cycle pulse: store written; SB pops its entry
// - mem_rd_o         out  1          memory line read request
// - mem_wr_o         out  1          memory write request
// - mem_addr_o       out  ADDR_SIZE  memory address
// - mem_wr_data_o    out  WORD_SIZE  memory write data
// - mem_type_o       out  2          memory write data type
// - mem_ready_i      in   1          memory completes current transaction (1-cycle pulse)
// - mem_rd_data_i    in   LANE_SIZE  read line, valid with mem_ready_i
// - err_timeout_o    out  1          sticky watchdog error
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; in-flight transaction dropped; priority pointer = DC.
// - FSM states: IDLE, DC_WAIT, IC_WAIT, SB_WAIT (mem_arb_state_e).
// - IDLE: pick a winner from the requests sampled this cycle. Next cycle: enter X_WAIT with registered mem_* outputs. Grant latency is 1 cycle.
// - X_WAIT: mem_rd_o/mem_wr_o, mem_addr_o, mem_wr_data_o and mem_type_o stay stable until mem_ready_i.
// - On mem_ready_i: the matching rdy/ack pulses in the next cycle (data registered) and the state returns to IDLE. Back-to-back grants are possible, giving a 2-cycle minimum per transaction.
// - Fill addresses are line-aligned: addr[BYTE_SIZE-1:0] forced to 0. Store addresses pass through unmodified.
// - Ordering: if dc_req_i && sb_req_i and both addresses are in the same line (ADDR_SIZE-BYTE_SIZE upper bits equal), SB wins regardless of priority mode.
// - A requester whose req drops before grant is ignored. Req drop after grant does not abort the transaction.
// - Watchdog: 8-bit counter, cleared on entry to any X_WAIT, increments while waiting. At TIMEOUT it sets err_timeout_o (sticky until rst_i) and the counter saturates. The FSM keeps waiting.
// - mem_ready_i in IDLE is ignored.
// - mem_rd_data_i drives both dc_data_o and ic_data_o (registered). Only the rdy pulse qualifies the data.
// CONFIGURATION
// - SEGRE_MEM_ARB_RR_EN defined: round-robin DC->SB->IC. The pointer advances past the winner on each grant; the ordering rule still overrides.
// - SEGRE_MEM_ARB_RR_EN undefined: fixed priority DC > SB > IC.
// STRUCTURE
// - segre_pkg gains:
//   - mem_arb_state_e {MEM_ARB_IDLE, MEM_ARB_DC_WAIT, MEM_ARB_IC_WAIT, MEM_ARB_SB_WAIT}
//   - mem_arb_req_e {ARB_DC, ARB_SB, ARB_IC}
//   - parameter MEM_ARB_TIMEOUT
// - One sub-module: segre_mem_arb_picker. It is combinational and computes the winner from the requests, the same-line check and the RR pointer.
// TESTING
// - Single dc_req_i addr 0x0000_1234, mem_ready_i 3 cycles after mem_rd_o:
//   - mem_addr_o = 0x0000_1230.
//   - dc_rdy_o pulses one cycle after mem_ready_i with dc_data_o = mem_rd_data_i.
// - dc/ic/sb requests in the same cycle, different lines:
//   - Fixed priority: grant order DC, SB, IC.
//   - RR_EN: same order first, then rotation continues from IC.
// - dc_addr_i 0x100 and sb_addr_i 0x108 (same line), both requested:
//   - mem_wr_o is issued first with sb_data_i and sb_ack_o pulses.
//   - mem_rd_o for 0x100 follows.
// - mem_ready_i never arrives for an SB write:
//   - err_timeout_o rises after 255 wait cycles.
//   - mem_wr_o is still held.
// - rst_i asserted mid DC_WAIT:
//   - Next cycle all outputs are 0 and the state is IDLE.
//   - A late mem_ready_i produces no dc_rdy_o.
// - mem_ready_i pulsed while IDLE with no requests -> no rdy/ack output.

Source files
------------

// File: rtl/segre_pkg.sv
// Shared types for the memory-port arbiter: FSM states, requester ids and the watchdog limit.
package segre_pkg;

   parameter int MEM_ARB_TIMEOUT = 255;

   typedef enum logic [1:0] {
      MEMOP_BYTE,
      MEMOP_HALF,
      MEMOP_WORD
   } memop_data_type_e;

   typedef enum logic [1:0] {
      MEM_ARB_IDLE,
      MEM_ARB_DC_WAIT,
      MEM_ARB_IC_WAIT,
      MEM_ARB_SB_WAIT
   } mem_arb_state_e;

   typedef enum logic [1:0] {
      ARB_DC,
      ARB_SB,
      ARB_IC
   } mem_arb_req_e;

   // Round-robin order is DC -> SB -> IC -> DC; the pointer moves past the winner.
   function automatic mem_arb_req_e arb_next_ptr(input mem_arb_req_e winner);
      case (winner)
         ARB_DC:  return ARB_SB;
         ARB_SB:  return ARB_IC;
         default: return ARB_DC;
      endcase
   endfunction

endpackage

// File: rtl/segre_mem_arb_picker.sv
// Combinational winner selection among DC/SB/IC; a store to the D-cache miss line always goes first.
// SEGRE_MEM_ARB_RR_EN selects round-robin from rr_ptr_i, otherwise fixed DC > SB > IC.
module segre_mem_arb_picker
   import segre_pkg::*;
(
`ifdef SEGRE_MEM_ARB_RR_EN
   input  mem_arb_req_e rr_ptr_i,
`endif
   input  logic         dc_req_i,
   input  logic         ic_req_i,
   input  logic         sb_req_i,
   input  logic         same_line_i,
   output logic         gnt_vld_o,
   output mem_arb_req_e gnt_o
);

   always_comb begin
      gnt_vld_o = dc_req_i | ic_req_i | sb_req_i;
      gnt_o     = ARB_DC;
      if (dc_req_i && sb_req_i && same_line_i) begin
         gnt_o = ARB_SB;
      end else begin
`ifdef SEGRE_MEM_ARB_RR_EN
         case (rr_ptr_i)
            ARB_SB: begin
               if (sb_req_i)      gnt_o = ARB_SB;
               else if (ic_req_i) gnt_o = ARB_IC;
               else               gnt_o = ARB_DC;
            end
            ARB_IC: begin
               if (ic_req_i)      gnt_o = ARB_IC;
               else if (dc_req_i) gnt_o = ARB_DC;
               else               gnt_o = ARB_SB;
            end
            default: begin
               if (dc_req_i)      gnt_o = ARB_DC;
               else if (sb_req_i) gnt_o = ARB_SB;
               else               gnt_o = ARB_IC;
            end
         endcase
`else
         if (dc_req_i)      gnt_o = ARB_DC;
         else if (sb_req_i) gnt_o = ARB_SB;
         else               gnt_o = ARB_IC;
`endif
      end
   end

endmodule

// File: rtl/segre_mem_arbiter.sv
// Serialises D-cache fills, I-cache fills and store-buffer drains onto one memory port, with a sticky latency watchdog.
// Optional round-robin arbitration via SEGRE_MEM_ARB_RR_EN (default build: fixed DC > SB > IC).
module segre_mem_arbiter
   import segre_pkg::*;
#(
   parameter int ADDR_SIZE = 32,
   parameter int WORD_SIZE = 32,
   parameter int LANE_SIZE = 128,
   parameter int BYTE_SIZE = 4,
   parameter int TIMEOUT   = MEM_ARB_TIMEOUT
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 dc_req_i,
   input  logic [ADDR_SIZE-1:0] dc_addr_i,
   output logic                 dc_rdy_o,
   output logic [LANE_SIZE-1:0] dc_data_o,
   input  logic                 ic_req_i,
   input  logic [ADDR_SIZE-1:0] ic_addr_i,
   output logic                 ic_rdy_o,
   output logic [LANE_SIZE-1:0] ic_data_o,
   input  logic                 sb_req_i,
   input  logic [ADDR_SIZE-1:0] sb_addr_i,
   input  logic [WORD_SIZE-1:0] sb_data_i,
   input  logic [1:0]           sb_type_i,
   output logic                 sb_ack_o,
   output logic                 mem_rd_o,
   output logic                 mem_wr_o,
   output logic [ADDR_SIZE-1:0] mem_addr_o,
   output logic [WORD_SIZE-1:0] mem_wr_data_o,
   output logic [1:0]           mem_type_o,
   input  logic                 mem_ready_i,
   input  logic [LANE_SIZE-1:0] mem_rd_data_i,
   output logic                 err_timeout_o
);

   localparam logic [ADDR_SIZE-1:0] OFS_MASK = ADDR_SIZE'((1 << BYTE_SIZE) - 1);
   localparam logic [7:0]           WDOG_MAX = 8'(TIMEOUT);

   mem_arb_state_e       state_q, state_d;
   logic                 mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
   logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
   logic [WORD_SIZE-1:0] mem_wr_data_q, mem_wr_data_d;
   logic [1:0]           mem_type_q, mem_type_d;
   logic                 dc_rdy_q, dc_rdy_d, ic_rdy_q, ic_rdy_d, sb_ack_q, sb_ack_d;
   logic [LANE_SIZE-1:0] rd_data_q, rd_data_d;
   logic [7:0]           wdog_q, wdog_d;
   logic                 err_q, err_d;
`ifdef SEGRE_MEM_ARB_RR_EN
   mem_arb_req_e         rr_ptr_q, rr_ptr_d;
`endif

   logic         dc_req, ic_req, sb_req, same_line, gnt_vld;
   mem_arb_req_e gnt;

   // A requester still sees its req high during its own rdy/ack cycle; mask it so it is not re-granted.
   assign dc_req    = dc_req_i & ~dc_rdy_q;
   assign ic_req    = ic_req_i & ~ic_rdy_q;
   assign sb_req    = sb_req_i & ~sb_ack_q;
   assign same_line = dc_addr_i[ADDR_SIZE-1:BYTE_SIZE] == sb_addr_i[ADDR_SIZE-1:BYTE_SIZE];

   segre_mem_arb_picker u_picker (
`ifdef SEGRE_MEM_ARB_RR_EN
      .rr_ptr_i    (rr_ptr_q),
`endif
      .dc_req_i    (dc_req),
      .ic_req_i    (ic_req),
      .sb_req_i    (sb_req),
      .same_line_i (same_line),
      .gnt_vld_o   (gnt_vld),
      .gnt_o       (gnt)
   );

   always_comb begin
      state_d       = state_q;
      mem_rd_d      = mem_rd_q;
      mem_wr_d      = mem_wr_q;
      mem_addr_d    = mem_addr_q;
      mem_wr_data_d = mem_wr_data_q;
      mem_type_d    = mem_type_q;
      dc_rdy_d      = 1'b0;
      ic_rdy_d      = 1'b0;
      sb_ack_d      = 1'b0;
      rd_data_d     = rd_data_q;
      wdog_d        = wdog_q;
      err_d         = err_q;
`ifdef SEGRE_MEM_ARB_RR_EN
      rr_ptr_d      = rr_ptr_q;
`endif
      case (state_q)
         MEM_ARB_IDLE: begin
            if (gnt_vld) begin
               wdog_d        = '0;
               mem_wr_data_d = '0;
               mem_type_d    = '0;
               case (gnt)
                  ARB_SB: begin
                     state_d       = MEM_ARB_SB_WAIT;
                     mem_wr_d      = 1'b1;
                     mem_addr_d    = sb_addr_i;
                     mem_wr_data_d = sb_data_i;
                     mem_type_d    = sb_type_i;
                  end
                  ARB_IC: begin
                     state_d    = MEM_ARB_IC_WAIT;
                     mem_rd_d   = 1'b1;
                     mem_addr_d = ic_addr_i & ~OFS_MASK;
                  end
                  default: begin
                     state_d    = MEM_ARB_DC_WAIT;
                     mem_rd_d   = 1'b1;
                     mem_addr_d = dc_addr_i & ~OFS_MASK;
                  end
               endcase
`ifdef SEGRE_MEM_ARB_RR_EN
               rr_ptr_d = arb_next_ptr(gnt);
`endif
            end
         end
         default: begin
            if (mem_ready_i) begin
               state_d       = MEM_ARB_IDLE;
               mem_rd_d      = 1'b0;
               mem_wr_d      = 1'b0;
               mem_addr_d    = '0;
               mem_wr_data_d = '0;
               mem_type_d    = '0;
               rd_data_d     = mem_rd_data_i;
               dc_rdy_d      = (state_q == MEM_ARB_DC_WAIT);
               ic_rdy_d      = (state_q == MEM_ARB_IC_WAIT);
               sb_ack_d      = (state_q == MEM_ARB_SB_WAIT);
            end else begin
               // Counter saturates at the limit; the FSM keeps waiting regardless.
               if (wdog_q != WDOG_MAX) wdog_d = wdog_q + 8'd1;
               if (wdog_q >= WDOG_MAX - 8'd1) err_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= MEM_ARB_IDLE;
         mem_rd_q      <= 1'b0;
         mem_wr_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wr_data_q <= '0;
         mem_type_q    <= '0;
         dc_rdy_q      <= 1'b0;
         ic_rdy_q      <= 1'b0;
         sb_ack_q      <= 1'b0;
         rd_data_q     <= '0;
         wdog_q        <= '0;
         err_q         <= 1'b0;
`ifdef SEGRE_MEM_ARB_RR_EN
         rr_ptr_q      <= ARB_DC;
`endif
      end else begin
         state_q       <= state_d;
         mem_rd_q      <= mem_rd_d;
         mem_wr_q      <= mem_wr_d;
         mem_addr_q    <= mem_addr_d;
         mem_wr_data_q <= mem_wr_data_d;
         mem_type_q    <= mem_type_d;
         dc_rdy_q      <= dc_rdy_d;
         ic_rdy_q      <= ic_rdy_d;
         sb_ack_q      <= sb_ack_d;
         rd_data_q     <= rd_data_d;
         wdog_q        <= wdog_d;
         err_q         <= err_d;
`ifdef SEGRE_MEM_ARB_RR_EN
         rr_ptr_q      <= rr_ptr_d;
`endif
      end
   end

   assign dc_rdy_o      = dc_rdy_q;
   assign ic_rdy_o      = ic_rdy_q;
   assign sb_ack_o      = sb_ack_q;
   assign dc_data_o     = rd_data_q;
   assign ic_data_o     = rd_data_q;
   assign mem_rd_o      = mem_rd_q;
   assign mem_wr_o      = mem_wr_q;
   assign mem_addr_o    = mem_addr_q;
   assign mem_wr_data_o = mem_wr_data_q;
   assign mem_type_o    = mem_type_q;
   assign err_timeout_o = err_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed bench for segre_mem_arbiter: expected memory transactions are queued when requests are raised
// and checked as the arbiter issues them; inputs change and outputs are sampled on the falling edge.
module tb_segre_mem_arbiter;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         dc_req_i, ic_req_i, sb_req_i;
   logic [31:0]  dc_addr_i, ic_addr_i, sb_addr_i, sb_data_i;
   logic [1:0]   sb_type_i;
   logic         dc_rdy_o, ic_rdy_o, sb_ack_o;
   logic [127:0] dc_data_o, ic_data_o;
   logic         mem_rd_o, mem_wr_o;
   logic [31:0]  mem_addr_o, mem_wr_data_o;
   logic [1:0]   mem_type_o;
   logic         mem_ready_i;
   logic [127:0] mem_rd_data_i;
   logic         err_timeout_o;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  typ;
      int          who;   // 0 = DC, 1 = SB, 2 = IC
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   segre_mem_arbiter dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .dc_req_i      (dc_req_i),
      .dc_addr_i     (dc_addr_i),
      .dc_rdy_o      (dc_rdy_o),
      .dc_data_o     (dc_data_o),
      .ic_req_i      (ic_req_i),
      .ic_addr_i     (ic_addr_i),
      .ic_rdy_o      (ic_rdy_o),
      .ic_data_o     (ic_data_o),
      .sb_req_i      (sb_req_i),
      .sb_addr_i     (sb_addr_i),
      .sb_data_i     (sb_data_i),
      .sb_type_i     (sb_type_i),
      .sb_ack_o      (sb_ack_o),
      .mem_rd_o      (mem_rd_o),
      .mem_wr_o      (mem_wr_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wr_data_o (mem_wr_data_o),
      .mem_type_o    (mem_type_o),
      .mem_ready_i   (mem_ready_i),
      .mem_rd_data_i (mem_rd_data_i),
      .err_timeout_o (err_timeout_o)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] typ, input int who);
      exp_t e;
      e.rd = rd; e.wr = wr; e.addr = addr; e.data = data; e.typ = typ; e.who = who;
      exp_q.push_back(e);
   endtask

   task automatic wait_grant(input string tag);
      int cyc = 0;
      while (!(mem_rd_o || mem_wr_o) && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check(tag, mem_rd_o || mem_wr_o, 1'b1);
   endtask

   // Accept the next issued transaction, compare it with the queue head, complete it after lat cycles.
   task automatic serve(input int lat, input logic [127:0] rdata);
      exp_t e;
      wait_grant("grant_seen");
      check("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      check($sformatf("rd_who%0d", e.who), mem_rd_o, e.rd);
      check($sformatf("wr_who%0d", e.who), mem_wr_o, e.wr);
      check($sformatf("addr_who%0d", e.who), mem_addr_o, e.addr);
      if (e.wr) begin
         check("wr_data", mem_wr_data_o, e.data);
         check("wr_type", mem_type_o, e.typ);
      end
      repeat (lat) @(negedge clk);
      check($sformatf("addr_stable_who%0d", e.who), mem_addr_o, e.addr);
      check($sformatf("req_stable_who%0d", e.who), {mem_rd_o, mem_wr_o}, {e.rd, e.wr});
      mem_ready_i   = 1'b1;
      mem_rd_data_i = rdata;
      @(negedge clk);
      mem_ready_i = 1'b0;
      check($sformatf("dc_rdy_who%0d", e.who), dc_rdy_o, e.who == 0);
      check($sformatf("sb_ack_who%0d", e.who), sb_ack_o, e.who == 1);
      check($sformatf("ic_rdy_who%0d", e.who), ic_rdy_o, e.who == 2);
      if (e.who == 0) check("dc_data", dc_data_o, rdata);
      if (e.who == 2) check("ic_data", ic_data_o, rdata);
      if (e.who == 0) dc_req_i = 1'b0;
      if (e.who == 1) sb_req_i = 1'b0;
      if (e.who == 2) ic_req_i = 1'b0;
      @(negedge clk);
      check($sformatf("pulse_end_who%0d", e.who), {dc_rdy_o, sb_ack_o, ic_rdy_o}, 3'b000);
   endtask

   initial begin
      #200us;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      rst_i = 1'b1;
      dc_req_i = 1'b0; ic_req_i = 1'b0; sb_req_i = 1'b0;
      dc_addr_i = '0; ic_addr_i = '0; sb_addr_i = '0; sb_data_i = '0; sb_type_i = '0;
      mem_ready_i = 1'b0; mem_rd_data_i = '0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_mem_rd", mem_rd_o, 1'b0);
      check("rst_mem_wr", mem_wr_o, 1'b0);
      check("rst_mem_addr", mem_addr_o, 32'h0);
      check("rst_rdy_ack", {dc_rdy_o, ic_rdy_o, sb_ack_o}, 3'b000);
      check("rst_err", err_timeout_o, 1'b0);
      rst_i = 1'b0;
      @(negedge clk);

      // Single D-cache fill: offset bits cleared, data returned one cycle after mem_ready_i
      dc_req_i = 1'b1; dc_addr_i = 32'h0000_1234;
      push_exp(1'b1, 1'b0, 32'h0000_1230, 32'h0, 2'd0, 0);
      @(negedge clk);
      check("grant_latency", mem_rd_o, 1'b1);
      serve(2, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_1234);

      // mem_ready_i while idle with nothing pending
      mem_ready_i = 1'b1;
      @(negedge clk);
      mem_ready_i = 1'b0;
      check("idle_ready_pulses", {dc_rdy_o, ic_rdy_o, sb_ack_o}, 3'b000);
      check("idle_ready_mem", {mem_rd_o, mem_wr_o}, 2'b00);

      // All three requesters, different lines: DC, then SB, then IC
      dc_req_i = 1'b1; dc_addr_i = 32'h0000_4000;
      ic_req_i = 1'b1; ic_addr_i = 32'h0000_5004;
      sb_req_i = 1'b1; sb_addr_i = 32'h0000_6008; sb_data_i = 32'hA5A5_5A5A; sb_type_i = 2'd2;
      push_exp(1'b1, 1'b0, 32'h0000_4000, 32'h0, 2'd0, 0);
      push_exp(1'b0, 1'b1, 32'h0000_6008, 32'hA5A5_5A5A, 2'd2, 1);
      push_exp(1'b1, 1'b0, 32'h0000_5000, 32'h0, 2'd0, 2);
      serve(1, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
      serve(0, 128'h0);
      serve(2, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000);

      // Store to the same line as the D-cache miss must be written first
      dc_req_i = 1'b1; dc_addr_i = 32'h0000_0100;
      sb_req_i = 1'b1; sb_addr_i = 32'h0000_0108; sb_data_i = 32'h1122_3344; sb_type_i = 2'd0;
      push_exp(1'b0, 1'b1, 32'h0000_0108, 32'h1122_3344, 2'd0, 1);
      push_exp(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2'd0, 0);
      serve(2, 128'h0);
      serve(1, 128'hCAFE_F00D_0000_0001_0000_0002_0000_0003);

      // Watchdog: memory never answers a store
      sb_req_i = 1'b1; sb_addr_i = 32'h0000_2000; sb_data_i = 32'h0000_0055; sb_type_i = 2'd1;
      wait_grant("wdog_grant");
      repeat (254) @(negedge clk);
      check("wdog_before_limit", err_timeout_o, 1'b0);
      @(negedge clk);
      check("wdog_at_limit", err_timeout_o, 1'b1);
      check("wdog_wr_held", mem_wr_o, 1'b1);
      check("wdog_addr_held", mem_addr_o, 32'h0000_2000);
      repeat (3) @(negedge clk);
      check("wdog_sticky", err_timeout_o, 1'b1);
      rst_i = 1'b1; sb_req_i = 1'b0;
      @(negedge clk);
      check("wdog_rst_err", err_timeout_o, 1'b0);
      check("wdog_rst_wr", mem_wr_o, 1'b0);
      rst_i = 1'b0;

      // Reset during a D-cache wait; a late mem_ready_i must not produce dc_rdy_o
      dc_req_i = 1'b1; dc_addr_i = 32'h0000_3008;
      wait_grant("rst_mid_grant");
      check("rst_mid_addr", mem_addr_o, 32'h0000_3000);
      rst_i = 1'b1; dc_req_i = 1'b0;
      @(negedge clk);
      check("rst_mid_mem", {mem_rd_o, mem_wr_o}, 2'b00);
      check("rst_mid_addr0", mem_addr_o, 32'h0);
      check("rst_mid_data0", dc_data_o, 128'h0);
      rst_i = 1'b0;
      mem_ready_i = 1'b1; mem_rd_data_i = 128'h5555;
      @(negedge clk);
      mem_ready_i = 1'b0;
      check("late_ready_no_rdy", dc_rdy_o, 1'b0);
      @(negedge clk);
      check("late_ready_idle", {dc_rdy_o, mem_rd_o, mem_wr_o}, 3'b000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
